// File: rtl/fmap_collector.sv
// fmap_collector: collects a stream of FP16 feature-map pixels into one flat frame register for the pooling layer.
// Latency: an accepted pixel appears on frameOut one cycle later; frameValid rises the cycle after the last pixel is accepted.
// Backpressure: pixReady drops while a complete frame is held (HOLD) and returns the cycle after frameAck is sampled.
//
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   pixIn/pixValid/pixReady - pixel stream in (valid/ready)
//   frameOut/frameValid     - flat frame, pixel (k,i,j) at (k*inputH*inputW + i*inputW + j)*DATA_WIDTH
//   frameAck                - consumer has taken the held frame
//   pixIdx                  - linear slot index of the next pixel to be written
//
// Compile-time option: FMAP_RELU_EN - when defined, pixels with the sign bit set are stored as zero.
module fmap_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 6,
  parameter int inputH     = 28,
  parameter int inputW     = 28,
  localparam int N         = Depth * inputH * inputW,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pixIn,
  input  logic                    pixValid,
  output logic                    pixReady,
  output logic [N*DATA_WIDTH-1:0] frameOut,
  output logic                    frameValid,
  input  logic                    frameAck,
  output logic [IDX_W-1:0]        pixIdx
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N*DATA_WIDTH-1:0] frame_q;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_dat;

  // Write-path data: optional ReLU clamps anything with the sign bit set
  // (negatives, -0, negative NaN/Inf) to +0; the pixel is otherwise untouched.
`ifdef FMAP_RELU_EN
  assign wr_dat = pixIn[DATA_WIDTH-1] ? '0 : pixIn;
`else
  assign wr_dat = pixIn;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (pixValid) begin
          wr_en = 1'b1;
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (frameAck) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Only the addressed slot is written; others keep the previous frame.
      if (wr_en) begin
        frame_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= wr_dat;
      end
    end
  end

  // Handshake outputs decode registered state only.
  assign pixReady   = (state_q == COLLECT);
  assign frameValid = (state_q == HOLD);
  assign frameOut   = frame_q;
  assign pixIdx     = idx_q;

endmodule

// File: tb/tb_fmap_collector.sv
module tb_fmap_collector;

  localparam int SN = 16;
  localparam int BN = 4704;

`ifdef FMAP_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Small DUT: Depth=1, 4x4
  logic [15:0]      s_pix;
  logic             s_v, s_rdy, s_fv, s_ack;
  logic [SN*16-1:0] s_fo;
  logic [3:0]       s_idx;

  // Default-size DUT
  logic [15:0]      b_pix;
  logic             b_v, b_rdy, b_fv, b_ack;
  logic [BN*16-1:0] b_fo;
  logic [12:0]      b_idx;

  fmap_collector #(.DATA_WIDTH(16), .Depth(1), .inputH(4), .inputW(4)) u_small (
    .clk(clk), .reset(reset), .pixIn(s_pix), .pixValid(s_v), .pixReady(s_rdy),
    .frameOut(s_fo), .frameValid(s_fv), .frameAck(s_ack), .pixIdx(s_idx)
  );

  fmap_collector #(.DATA_WIDTH(16), .Depth(6), .inputH(28), .inputW(28)) u_big (
    .clk(clk), .reset(reset), .pixIn(b_pix), .pixValid(b_v), .pixReady(b_rdy),
    .frameOut(b_fo), .frameValid(b_fv), .frameAck(b_ack), .pixIdx(b_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] relu_exp(input logic [15:0] x);
    return (RELU && x[15]) ? 16'h0000 : x;
  endfunction

  function automatic logic [15:0] sslot(input int n);
    return s_fo[n*16 +: 16];
  endfunction

  function automatic logic [15:0] bslot(input int n);
    return b_fo[n*16 +: 16];
  endfunction

  // Advance one clock and sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] pix;
    logic        ack;
    logic        rdy;
    logic        fv;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl[20];

  int accepts;
  bit done;

  initial begin
    // Vector table: one entry per cycle, expected outputs after the edge.
    tbl[0] = '{1'b1, 16'hBC00, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[1] = '{1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[2] = '{1'b1, 16'h3C00, 1'b1, 1'b1, 1'b0, 4'd3};  // ack in COLLECT ignored
    tbl[3] = '{1'b1, 16'hFE00, 1'b0, 1'b1, 1'b0, 4'd4};
    tbl[4] = '{1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 4'd4};  // idle cycle, ack ignored
    for (int e = 5; e <= 15; e++)
      tbl[e] = '{1'b1, 16'h3C00 + 16'(e - 1), 1'b0, 1'b1, 1'b0, 4'(e)};
    tbl[16] = '{1'b1, 16'h3C0F, 1'b0, 1'b0, 1'b1, 4'd0};  // last pixel -> HOLD
    tbl[17] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 4'd0};  // stalled, not written
    tbl[18] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 4'd0};  // ack taken, pixel not accepted
    tbl[19] = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 4'd1};

    reset = 1'b1;
    s_v = 0; s_pix = 0; s_ack = 0;
    b_v = 0; b_pix = 0; b_ack = 0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_s_rdy", 32'(s_rdy), 32'd1);
    check("rst_s_fv", 32'(s_fv), 32'd0);
    check("rst_s_idx", 32'(s_idx), 32'd0);
    check("rst_s_fo_zero", 32'(s_fo == '0), 32'd1);
    check("rst_b_rdy", 32'(b_rdy), 32'd1);
    check("rst_b_fv", 32'(b_fv), 32'd0);
    check("rst_b_fo_zero", 32'(b_fo == '0), 32'd1);

    // Full 16-pixel frame with valid held high
    for (int n = 0; n < SN; n++) begin
      s_v = 1; s_pix = 16'h3C00 + 16'(n);
      step();
      if (n < SN - 1) check("s_fv_early", 32'(s_fv), 32'd0);
    end
    check("s_fv_after16", 32'(s_fv), 32'd1);
    check("s_rdy_hold", 32'(s_rdy), 32'd0);
    for (int n = 0; n < SN; n++) check($sformatf("s_slot%0d", n), 32'(sslot(n)), 32'(relu_exp(16'h3C00 + 16'(n))));

    // Ack withheld 5 cycles, pixValid high
    s_pix = 16'hAAAA;
    for (int c = 0; c < 5; c++) begin
      step();
      check("s_hold_rdy", 32'(s_rdy), 32'd0);
      check("s_hold_fv", 32'(s_fv), 32'd1);
    end
    check("s_hold_slot0", 32'(sslot(0)), 32'(relu_exp(16'h3C00)));
    s_ack = 1;
    step();
    s_ack = 0;
    check("s_ack_rdy", 32'(s_rdy), 32'd1);
    check("s_ack_fv", 32'(s_fv), 32'd0);
    s_pix = 16'h2000;
    step();
    check("s_f2_slot0", 32'(sslot(0)), 32'h2000);
    check("s_f2_slot1_intact", 32'(sslot(1)), 32'(relu_exp(16'h3C01)));
    check("s_f2_idx", 32'(s_idx), 32'd1);

    // Reset mid-frame after 7 pixels
    for (int n = 1; n < 7; n++) begin
      s_pix = 16'h2000 + 16'(n);
      step();
    end
    check("s_mid_idx7", 32'(s_idx), 32'd7);
    s_v = 0;
    reset = 1;
    step();
    reset = 0;
    step();
    check("s_mrst_idx", 32'(s_idx), 32'd0);
    check("s_mrst_fo", 32'(s_fo == '0), 32'd1);
    check("s_mrst_fv", 32'(s_fv), 32'd0);
    check("s_mrst_rdy", 32'(s_rdy), 32'd1);
    for (int n = 0; n < SN; n++) begin
      s_v = 1; s_pix = 16'h4000 + 16'(n);
      step();
      if (n < SN - 1) check("s_fresh_fv_early", 32'(s_fv), 32'd0);
    end
    check("s_fresh_fv", 32'(s_fv), 32'd1);
    check("s_fresh_slot15", 32'(sslot(15)), 32'h400F);
    s_v = 0; s_ack = 1;
    step();
    s_ack = 0;
    check("s_fresh_ack_rdy", 32'(s_rdy), 32'd1);

    // Table-driven sequence: ReLU values, ack in COLLECT, stall in HOLD
    for (int e = 0; e < 20; e++) begin
      s_v = tbl[e].v; s_pix = tbl[e].pix; s_ack = tbl[e].ack;
      step();
      check($sformatf("tbl%0d_rdy", e), 32'(s_rdy), 32'(tbl[e].rdy));
      check($sformatf("tbl%0d_fv", e), 32'(s_fv), 32'(tbl[e].fv));
      check($sformatf("tbl%0d_idx", e), 32'(s_idx), 32'(tbl[e].idx));
      if (e == 17) begin
        check("relu_bc00", 32'(sslot(0)), 32'(relu_exp(16'hBC00)));
        check("relu_8000", 32'(sslot(1)), 32'(relu_exp(16'h8000)));
        check("relu_3c00", 32'(sslot(2)), 32'h3C00);
        check("relu_fe00", 32'(sslot(3)), 32'(relu_exp(16'hFE00)));
        check("tbl_slot4", 32'(sslot(4)), 32'h3C04);
        check("tbl_slot15", 32'(sslot(15)), 32'h3C0F);
      end
    end
    check("tbl_f2_slot0", 32'(sslot(0)), 32'h7777);
    check("tbl_f2_slot15_intact", 32'(sslot(15)), 32'h3C0F);
    s_v = 0; s_ack = 0;

    // Default-size DUT with pixValid toggling every other cycle
    accepts = 0;
    done = 0;
    b_v = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      b_v = ~b_v;
      b_pix = 16'(accepts);
      if (b_v && b_rdy) accepts++;
      step();
      if (b_fv) done = 1;
    end
    check("b_done", 32'(done), 32'd1);
    check("b_accepts", 32'(accepts), 32'(BN));
    check("b_last_slot", 32'(bslot(BN - 1)), 32'h125F);
    check("b_slot0", 32'(bslot(0)), 32'h0000);
    check("b_slot1000", 32'(bslot(1000)), 32'd1000);
    check("b_idx_wrap", 32'(b_idx), 32'd0);
    check("b_rdy_hold", 32'(b_rdy), 32'd0);
    b_v = 0; b_ack = 1;
    step();
    b_ack = 0;
    check("b_ack_fv", 32'(b_fv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
